branch_predictor: RTL and testbench

//   Parametrised direct-mapped branch predictor (BHT of saturating counters plus BTB) for the IF stage of the
//   5-stage RISC-V pipeline. Gives IF a combinational taken/target guess for the current PC. The ID stage,

---
 rtl/riscv_pkg.sv | 18 +
 rtl/sat_counter.sv | 29 ++
 rtl/branch_predictor.sv | 112 +++++++++++
 tb/tb_branch_predictor.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: instruction length, major opcodes and the
// table-index width helper used by the predictor, PC and hazard logic.
package riscv_pkg;

  localparam int INSTR_LEN = 4;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Index width for a power-of-two table; never narrower than one bit.
  function automatic int idx_w(input int entries);
    return (entries <= 2) ? 1 : $clog2(entries);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with a load port and an externally supplied
// reset value; one instance holds the direction state of one table entry.
module sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] rst_val,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  // Load wins over counting; counting stops at either end of the range.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= rst_val;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end else if (dec && (cnt != {CNT_W{1'b0}})) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB giving IF a 0-cycle taken/target guess, trained by
// branch resolution in ID. Flop-based so reset and flush finish in one cycle.
module branch_predictor
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 2,
  parameter int TAG_W     = 8,
  parameter int INSTR_LEN = riscv_pkg::INSTR_LEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_mispred_i,
  input  logic            flush_i,
  output logic [31:0]     mispred_cnt_o
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - 1'b1;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [XLEN-1:0]  fall_through;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_en;

  logic             unused_bits;

  assign lk_idx  = pc_i[2 +: IDX_W];
  assign lk_tag  = pc_i[2 + IDX_W +: TAG_W];
  assign upd_idx = upd_pc_i[2 +: IDX_W];
  assign upd_tag = upd_pc_i[2 + IDX_W +: TAG_W];

  assign unused_bits = ^{pc_i, upd_pc_i};

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign lk_hit        = start_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign fall_through  = pc_i + XLEN'(INSTR_LEN);
  assign pred_taken_o  = lk_hit & cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : fall_through;

  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_en  = start_i & upd_valid_i & ~flush_i;

  // Flush clears only the valid bits; a taken miss overwrites the whole entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int e = 0; e < ENTRIES; e++) begin
        valid_q[e]  <= 1'b0;
        tag_q[e]    <= '0;
        target_q[e] <= '0;
      end
    end else if (start_i) begin
      if (flush_i) begin
        for (int e = 0; e < ENTRIES; e++) begin
          valid_q[e] <= 1'b0;
        end
      end else if (upd_valid_i && upd_taken_i) begin
        target_q[upd_idx] <= upd_target_i;
        if (!upd_hit) begin
          valid_q[upd_idx] <= 1'b1;
          tag_q[upd_idx]   <= upd_tag;
        end
      end
    end
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_cnt
    logic sel;
    assign sel = upd_en & (upd_idx == IDX_W'(e));

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rst_val  (CNT_WEAK_NT),
      .inc      (sel & upd_hit & upd_taken_i),
      .dec      (sel & upd_hit & ~upd_taken_i),
      .load     (sel & ~upd_hit & upd_taken_i),
      .load_val (CNT_WEAK_T),
      .cnt      (cnt_q[e])
    );
  end

  // Misprediction statistics survive a table flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mispred_cnt_o <= '0;
    end else if (start_i && upd_valid_i && upd_mispred_i && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
      mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic compared against a behavioural table model.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispred_i;
  logic        flush_i;
  logic [31:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;

  bit          m_valid  [16];
  int          m_tag    [16];
  logic [31:0] m_target [16];
  int          m_cnt    [16];
  longint      m_mis;

  always #5 clk_i = ~clk_i;

  branch_predictor dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .pc_i          (pc_i),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .upd_mispred_i (upd_mispred_i),
    .flush_i       (flush_i),
    .mispred_cnt_o (mispred_cnt_o)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'(pc[13:6]);
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 16; e++) begin
      m_valid[e]  = 1'b0;
      m_tag[e]    = 0;
      m_target[e] = 32'h0;
      m_cnt[e]    = 1;
    end
    m_mis = 0;
  endtask

  // Applies the training rules to the model using the inputs present at the edge.
  task automatic model_clock();
    int i;
    bit hit;
    if (!start_i) return;
    if (upd_valid_i && upd_mispred_i && m_mis < 64'hFFFF_FFFF) m_mis++;
    if (flush_i) begin
      for (int e = 0; e < 16; e++) m_valid[e] = 1'b0;
    end else if (upd_valid_i) begin
      i   = idx_of(upd_pc_i);
      hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc_i));
      if (hit && upd_taken_i) begin
        if (m_cnt[i] < 3) m_cnt[i]++;
        m_target[i] = upd_target_i;
      end else if (hit) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
      end else if (upd_taken_i) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upd_pc_i);
        m_target[i] = upd_target_i;
        m_cnt[i]    = 2;
      end
    end
  endtask

  task automatic idle();
    upd_valid_i   = 1'b0;
    upd_pc_i      = 32'h0;
    upd_taken_i   = 1'b0;
    upd_target_i  = 32'h0;
    upd_mispred_i = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_clock();
    @(negedge clk_i);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic mis);
    upd_valid_i   = 1'b1;
    upd_pc_i      = pc;
    upd_taken_i   = taken;
    upd_target_i  = tgt;
    upd_mispred_i = mis;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    start_i = 1'b1;
    idle();
    pc_i = 32'h40;
    model_reset();
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h44) begin
      errors++;
      $display("[TB] FAIL reset_lookup got taken=%0b target=%h want taken=0 target=00000044",
               pred_taken_o, pred_target_o);
    end
    checks++;
    if (mispred_cnt_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mispred got %h want 00000000", mispred_cnt_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_allocate();
    train(32'h40, 1'b1, 32'h100, 1'b1);
    pc_i = 32'h40;
    #1;
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h100) begin
      errors++;
      $display("[TB] FAIL allocate got taken=%0b target=%h want taken=1 target=00000100",
               pred_taken_o, pred_target_o);
    end
    checks++;
    if (mispred_cnt_o !== 32'd1) begin
      errors++;
      $display("[TB] FAIL allocate_mispred got %0d want 1", mispred_cnt_o);
    end
  endtask

  task automatic test_decrement();
    logic        exp_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        upd_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_g [5] = '{32'h44, 32'h44, 32'h44, 32'h44, 32'h120};
    for (int s = 0; s < 5; s++) begin
      train(32'h40, upd_t[s], 32'h120, 1'b0);
      pc_i = 32'h40;
      #1;
      checks++;
      if (pred_taken_o !== exp_t[s] || pred_target_o !== exp_g[s]) begin
        errors++;
        $display("[TB] FAIL saturate_step%0d got taken=%0b target=%h want taken=%0b target=%h",
                 s, pred_taken_o, pred_target_o, exp_t[s], exp_g[s]);
      end
    end
  endtask

  task automatic test_alias();
    pc_i = 32'h80;
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h84) begin
      errors++;
      $display("[TB] FAIL alias_lookup got taken=%0b target=%h want taken=0 target=00000084",
               pred_taken_o, pred_target_o);
    end
    train(32'h80, 1'b1, 32'h200, 1'b0);
    pc_i = 32'h40;
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h44) begin
      errors++;
      $display("[TB] FAIL alias_evict got taken=%0b target=%h want taken=0 target=00000044",
               pred_taken_o, pred_target_o);
    end
    pc_i = 32'h80;
    #1;
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin
      errors++;
      $display("[TB] FAIL alias_new got taken=%0b target=%h want taken=1 target=00000200",
               pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_flush();
    logic [31:0] pcs [3] = '{32'h40, 32'h44, 32'h80};
    train(32'h44, 1'b1, 32'h300, 1'b0);
    flush_i = 1'b1;
    train(32'h40, 1'b1, 32'h400, 1'b1);
    for (int k = 0; k < 3; k++) begin
      pc_i = pcs[k];
      #1;
      checks++;
      if (pred_taken_o !== 1'b0 || pred_target_o !== pcs[k] + 32'd4) begin
        errors++;
        $display("[TB] FAIL flush_pc%h got taken=%0b target=%h want taken=0", pcs[k],
                 pred_taken_o, pred_target_o);
      end
    end
    checks++;
    if (mispred_cnt_o !== 32'd2) begin
      errors++;
      $display("[TB] FAIL flush_mispred got %0d want 2", mispred_cnt_o);
    end
  endtask

  task automatic test_same_cycle();
    train(32'h40, 1'b1, 32'h100, 1'b0);
    upd_valid_i = 1'b1;
    upd_pc_i    = 32'h40;
    upd_taken_i = 1'b0;
    pc_i        = 32'h40;
    #1;
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h100) begin
      errors++;
      $display("[TB] FAIL same_cycle_old got taken=%0b target=%h want taken=1 target=00000100",
               pred_taken_o, pred_target_o);
    end
    tick();
    idle();
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h44) begin
      errors++;
      $display("[TB] FAIL same_cycle_new got taken=%0b target=%h want taken=0 target=00000044",
               pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_start_low();
    train(32'h40, 1'b1, 32'h100, 1'b0);
    start_i = 1'b0;
    pc_i    = 32'h40;
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h44) begin
      errors++;
      $display("[TB] FAIL start_low_lookup got taken=%0b target=%h want taken=0 target=00000044",
               pred_taken_o, pred_target_o);
    end
    train(32'h40, 1'b0, 32'h0, 1'b1);
    flush_i = 1'b1;
    train(32'h40, 1'b0, 32'h0, 1'b1);
    start_i = 1'b1;
    #1;
    checks++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h100) begin
      errors++;
      $display("[TB] FAIL start_low_hold got taken=%0b target=%h want taken=1 target=00000100",
               pred_taken_o, pred_target_o);
    end
    checks++;
    if (mispred_cnt_o !== 32'd2) begin
      errors++;
      $display("[TB] FAIL start_low_mispred got %0d want 2", mispred_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    upd_valid_i   = 1'b1;
    upd_pc_i      = 32'h80;
    upd_taken_i   = 1'b1;
    upd_target_i  = 32'h500;
    upd_mispred_i = 1'b1;
    pc_i          = 32'h40;
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h44 || mispred_cnt_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got taken=%0b target=%h mis=%0d want 0/00000044/0",
               pred_taken_o, pred_target_o, mispred_cnt_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    idle();
    pc_i = 32'h80;
    #1;
    checks++;
    if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h84 || mispred_cnt_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset_lost got taken=%0b target=%h mis=%0d want 0/00000084/0",
               pred_taken_o, pred_target_o, mispred_cnt_o);
    end
    @(negedge clk_i);
  endtask

  // Small tag/index space so random training and lookups collide often.
  task automatic test_random();
    int          i;
    bit          exp_taken;
    logic [31:0] exp_target;
    for (int n = 0; n < 600; n++) begin
      start_i       = ($urandom_range(0, 9) != 0);
      flush_i       = ($urandom_range(0, 29) == 0);
      upd_valid_i   = $urandom_range(0, 1);
      upd_pc_i      = {18'h0, 8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00};
      upd_taken_i   = ($urandom_range(0, 2) != 0);
      upd_target_i  = $urandom;
      upd_mispred_i = $urandom_range(0, 1);
      pc_i          = {18'h0, 8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'b00};
      if (n % 97 == 96) pc_i = 32'hFFFF_FFFC;
      #1;
      i          = idx_of(pc_i);
      exp_taken  = start_i && m_valid[i] && (m_tag[i] == tag_of(pc_i)) && (m_cnt[i] >= 2);
      exp_target = exp_taken ? m_target[i] : pc_i + 32'd4;
      checks++;
      if (pred_taken_o !== exp_taken || pred_target_o !== exp_target) begin
        errors++;
        $display("[TB] FAIL random_lookup n=%0d pc=%h got taken=%0b target=%h want taken=%0b target=%h",
                 n, pc_i, pred_taken_o, pred_target_o, exp_taken, exp_target);
      end
      checks++;
      if (mispred_cnt_o !== 32'(m_mis)) begin
        errors++;
        $display("[TB] FAIL random_mispred n=%0d got %0d want %0d", n, mispred_cnt_o, m_mis);
      end
      tick();
    end
    idle();
    start_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_decrement();
    test_alias();
    test_flush();
    test_same_cycle();
    test_start_low();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
